dac_seq: RTL and testbench

DAC_SEQ -- requirements
Module: dac_seq

---
 rtl/dac_pkg.sv | 16 +
 rtl/dac_seq_chreg.sv | 49 ++++
 rtl/dac_seq.sv | 143 ++++++++++++++
 tb/tb_dac_seq.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared definitions for the DAC channel sequencer: power FSM states and default parameters.
package dac_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } dac_state_e;

    localparam int DEF_NBITS     = 10;
    localparam int DEF_NCH       = 4;
    localparam int DEF_DIV       = 8;
    localparam int DEF_TSETTLE   = 16;
    localparam int DEF_AUTO_LOAD = 0;

endpackage

// File: rtl/dac_seq_chreg.sv
// One channel's double-buffered code: a shadow register written by the host and an
// active register that feeds the converter.
module dac_seq_chreg
    import dac_pkg::*;
#(
    parameter int NBITS     = DEF_NBITS,
    parameter int AUTO_LOAD = DEF_AUTO_LOAD
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             wr_i,
    input  logic             ldac_i,
    input  logic [NBITS-1:0] wr_data_i,
    output logic [NBITS-1:0] active_o
);

    logic [NBITS-1:0] shadow_q, shadow_d;
    logic [NBITS-1:0] active_q, active_d;

    // A write coinciding with LDAC wins for this channel's active value.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        if (wr_i) begin
            shadow_d = wr_data_i;
        end
        if (clr_i) begin
            active_d = '0;
        end else if (wr_i && ((AUTO_LOAD != 0) || ldac_i)) begin
            active_d = wr_data_i;
        end else if (ldac_i) begin
            active_d = shadow_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign active_o = active_q;

endmodule

// File: rtl/dac_seq.sv
// Multi-channel DAC sequencer: power-up settle FSM, host write port, LDAC transfer and
// a round-robin strobe that presents one channel's active code every DIV clocks.
module dac_seq
    import dac_pkg::*;
#(
    parameter int NBITS     = DEF_NBITS,
    parameter int NCH       = DEF_NCH,
    parameter int DIV       = DEF_DIV,
    parameter int TSETTLE   = DEF_TSETTLE,
    parameter int AUTO_LOAD = DEF_AUTO_LOAD,
    localparam int CHW      = $clog2(NCH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             PD,
    input  logic             WR_VALID,
    output logic             WR_READY,
    input  logic [CHW-1:0]   WR_CH,
    input  logic [NBITS-1:0] WR_DATA,
    input  logic             LDAC,
    output logic [NBITS-1:0] DAC_DATA,
    output logic [CHW-1:0]   DAC_CH,
    output logic             DAC_STB,
    output logic             PU_DONE,
    output logic             WR_ERR,
    output logic [1:0]       dbg_state_o
);

    localparam int SW = (TSETTLE > 1) ? $clog2(TSETTLE) : 1;
    localparam int DW = $clog2(DIV);

    dac_state_e       state_q, state_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [DW-1:0]    div_q, div_d;
    logic [CHW-1:0]   ptr_q, ptr_d;
    logic [NBITS-1:0] data_q, data_d;
    logic [CHW-1:0]   ch_q, ch_d;
    logic             stb_q, stb_d;
    logic             err_q, err_d;

    logic             accept;
    logic             wr_bad;
    logic             ldac_en;
    logic [NBITS-1:0] active [NCH];

    // Handshake: a write transfers on any rising edge where WR_VALID and WR_READY are both high;
    // WR_READY depends only on the FSM state, never on WR_VALID.
    assign WR_READY = (state_q != OFF);
    assign accept   = WR_VALID && WR_READY;
    assign wr_bad   = accept && (int'(WR_CH) >= NCH);
    assign ldac_en  = LDAC && (state_q != OFF);

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        dac_seq_chreg #(
            .NBITS     (NBITS),
            .AUTO_LOAD (AUTO_LOAD)
        ) u_chreg (
            .clk_i     (CLK),
            .rst_i     (RST),
            .clr_i     (PD),
            .wr_i      (accept && (WR_CH == CHW'(g))),
            .ldac_i    (ldac_en),
            .wr_data_i (WR_DATA),
            .active_o  (active[g])
        );
    end

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        div_d    = div_q;
        ptr_d    = ptr_q;
        data_d   = data_q;
        ch_d     = ch_q;
        stb_d    = 1'b0;
        err_d    = err_q | wr_bad;
        if (PD) begin
            state_d  = OFF;
            settle_d = '0;
            div_d    = '0;
            ptr_d    = '0;
            data_d   = '0;
            ch_d     = '0;
        end else begin
            case (state_q)
                OFF: begin
                    state_d  = SETTLE;
                    settle_d = SW'(TSETTLE - 1);
                end
                SETTLE: begin
                    if (settle_q == '0) begin
                        state_d = RUN;
                        div_d   = '0;
                    end else begin
                        settle_d = settle_q - 1'b1;
                    end
                end
                RUN: begin
                    if (div_q == DW'(DIV - 1)) begin
                        div_d  = '0;
                        stb_d  = 1'b1;
                        data_d = active[ptr_q];
                        ch_d   = ptr_q;
                        ptr_d  = (ptr_q == CHW'(NCH - 1)) ? '0 : ptr_q + 1'b1;
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                default: state_d = OFF;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= OFF;
            settle_q <= '0;
            div_q    <= '0;
            ptr_q    <= '0;
            data_q   <= '0;
            ch_q     <= '0;
            stb_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            div_q    <= div_d;
            ptr_q    <= ptr_d;
            data_q   <= data_d;
            ch_q     <= ch_d;
            stb_q    <= stb_d;
            err_q    <= err_d;
        end
    end

    assign DAC_DATA    = data_q;
    assign DAC_CH      = ch_q;
    assign DAC_STB     = stb_q;
    assign PU_DONE     = (state_q == RUN);
    assign WR_ERR      = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dac_seq.sv
// Bench for dac_seq: two instances (default 4-channel, and a 3-channel auto-load variant)
// driven with the same stimulus and compared each cycle against a timeline model.
module tb_dac_seq;
    import dac_pkg::*;

    logic       CLK;
    logic       RST;
    logic       PD;
    logic       WR_VALID;
    logic [1:0] WR_CH;
    logic [9:0] WR_DATA;
    logic       LDAC;

    logic       a_ready, a_stb, a_pu, a_err;
    logic [9:0] a_data;
    logic [1:0] a_ch, a_dbg;
    logic       b_ready, b_stb, b_pu, b_err;
    logic [9:0] b_data;
    logic [1:0] b_ch, b_dbg;

    int checks = 0;
    int errors = 0;

    int p_nch [2] = '{4, 3};
    int p_div [2] = '{8, 5};
    int p_ts  [2] = '{16, 4};
    int p_al  [2] = '{0, 1};

    int m_shadow [2][16];
    int m_active [2][16];
    int m_on [2], m_e [2], m_data [2], m_ch [2], m_stb [2], m_err [2];

    dac_seq #(.NBITS(10), .NCH(4), .DIV(8), .TSETTLE(16), .AUTO_LOAD(0)) dut_a (
        .CLK(CLK), .RST(RST), .PD(PD), .WR_VALID(WR_VALID), .WR_READY(a_ready),
        .WR_CH(WR_CH), .WR_DATA(WR_DATA), .LDAC(LDAC), .DAC_DATA(a_data), .DAC_CH(a_ch),
        .DAC_STB(a_stb), .PU_DONE(a_pu), .WR_ERR(a_err), .dbg_state_o(a_dbg)
    );

    dac_seq #(.NBITS(10), .NCH(3), .DIV(5), .TSETTLE(4), .AUTO_LOAD(1)) dut_b (
        .CLK(CLK), .RST(RST), .PD(PD), .WR_VALID(WR_VALID), .WR_READY(b_ready),
        .WR_CH(WR_CH), .WR_DATA(WR_DATA), .LDAC(LDAC), .DAC_DATA(b_data), .DAC_CH(b_ch),
        .DAC_STB(b_stb), .PU_DONE(b_pu), .WR_ERR(b_err), .dbg_state_o(b_dbg)
    );

    // clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_on[k] = 0; m_e[k] = 0; m_data[k] = 0; m_ch[k] = 0; m_stb[k] = 0; m_err[k] = 0;
            for (int i = 0; i < 16; i++) begin
                m_shadow[k][i] = 0;
                m_active[k][i] = 0;
            end
        end
    endtask

    // Timeline view: e counts edges since power-up began; RUN starts at e = TSETTLE+1
    // and the n-th strobe (n >= 1) lands DIV*n edges later on channel (n-1) mod NCH.
    task automatic model_step(input int k);
        int accept, ch_ok, run_e, n;
        int old_sh [16];
        accept = WR_VALID && m_on[k];
        ch_ok  = int'(WR_CH) < p_nch[k];
        if (accept && !ch_ok) m_err[k] = 1;
        for (int i = 0; i < 16; i++) old_sh[i] = m_shadow[k][i];
        if (accept && ch_ok) m_shadow[k][WR_CH] = int'(WR_DATA);
        if (PD) begin
            m_on[k] = 0; m_e[k] = 0; m_stb[k] = 0; m_data[k] = 0; m_ch[k] = 0;
            for (int i = 0; i < 16; i++) m_active[k][i] = 0;
        end else if (!m_on[k]) begin
            m_on[k] = 1; m_e[k] = 1; m_stb[k] = 0;
        end else begin
            m_e[k]++;
            run_e    = m_e[k] - (p_ts[k] + 1);
            m_stb[k] = (run_e > 0) && (run_e % p_div[k] == 0);
            if (m_stb[k]) begin
                n         = run_e / p_div[k] - 1;
                m_ch[k]   = n % p_nch[k];
                m_data[k] = m_active[k][m_ch[k]];
            end
            if (LDAC) for (int i = 0; i < p_nch[k]; i++) m_active[k][i] = old_sh[i];
            if (accept && ch_ok && (p_al[k] != 0 || LDAC)) m_active[k][WR_CH] = int'(WR_DATA);
        end
    endtask

    task automatic compare_dut(input int k);
        string      p;
        logic [9:0] d;
        logic [1:0] c, s;
        logic       st, pu, rd, er;
        int         exp_state;
        p = (k == 0) ? "A" : "B";
        if (k == 0) begin d = a_data; c = a_ch; s = a_dbg; st = a_stb; pu = a_pu; rd = a_ready; er = a_err; end
        else        begin d = b_data; c = b_ch; s = b_dbg; st = b_stb; pu = b_pu; rd = b_ready; er = b_err; end
        if (!m_on[k])                 exp_state = int'(OFF);
        else if (m_e[k] <= p_ts[k])   exp_state = int'(SETTLE);
        else                          exp_state = int'(RUN);
        check({p, "_dac_data"}, 32'(d), 32'(m_data[k]));
        check({p, "_dac_ch"},   32'(c), 32'(m_ch[k]));
        check({p, "_dac_stb"},  32'(st), 32'(m_stb[k]));
        check({p, "_pu_done"},  32'(pu), 32'(exp_state == int'(RUN)));
        check({p, "_wr_ready"}, 32'(rd), 32'(m_on[k]));
        check({p, "_wr_err"},   32'(er), 32'(m_err[k]));
        check({p, "_state"},    32'(s), 32'(exp_state));
    endtask

    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge CLK);
        #1;
        compare_dut(0);
        compare_dut(1);
    endtask

    task automatic idle();
        WR_VALID = 1'b0;
        LDAC     = 1'b0;
    endtask

    task automatic write(input logic [1:0] ch, input logic [9:0] data, input logic ld);
        WR_VALID = 1'b1;
        WR_CH    = ch;
        WR_DATA  = data;
        LDAC     = ld;
        tick();
        idle();
    endtask

    task automatic wait_stb(input int k, input int ch, input int exp, input int budget, input string tag);
        int found;
        found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            tick();
            if (k == 0 && a_stb && int'(a_ch) == ch) begin
                found = 1;
                check(tag, 32'(a_data), 32'(exp));
            end
            if (k == 1 && b_stb && int'(b_ch) == ch) begin
                found = 1;
                check(tag, 32'(b_data), 32'(exp));
            end
        end
        check({tag, "_strobe_seen"}, 32'(found), 32'd1);
    endtask

    initial begin
        RST = 1'b1; PD = 1'b1; WR_VALID = 1'b0; WR_CH = '0; WR_DATA = '0; LDAC = 1'b0;
        model_reset();
        #2;
        compare_dut(0);
        compare_dut(1);
        @(negedge CLK);
        RST = 1'b0;
        tick();
        tick();

        // power-up timing from PD falling
        PD = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        check("A_pu_before_17", 32'(a_pu), 32'd0);
        tick();
        check("A_pu_at_17", 32'(a_pu), 32'd1);
        for (int i = 0; i < 7; i++) tick();
        check("A_no_stb_at_24", 32'(a_stb), 32'd0);
        tick();
        check("A_first_stb_at_25", 32'(a_stb), 32'd1);
        check("A_first_stb_ch0", 32'(a_ch), 32'd0);

        // shadow write then LDAC
        write(2'd2, 10'h155, 1'b0);
        wait_stb(0, 2, 0, 80, "A_ch2_before_ldac");
        write(2'd0, 10'h000, 1'b0);
        LDAC = 1'b1; tick(); idle();
        wait_stb(0, 2, 'h155, 80, "A_ch2_after_ldac");

        // auto-load instance
        write(2'd1, 10'h3FF, 1'b0);
        wait_stb(1, 1, 'h3FF, 40, "B_ch1_autoload");

        // write and LDAC together; channel 3 is out of range for the 3-channel instance
        check("B_err_clear", 32'(b_err), 32'd0);
        write(2'd0, 10'h011, 1'b0);
        write(2'd3, 10'h0AA, 1'b1);
        check("B_err_set", 32'(b_err), 32'd1);
        wait_stb(0, 3, 'h0AA, 80, "A_ch3_wr_ldac");
        wait_stb(0, 0, 'h011, 80, "A_ch0_wr_ldac");
        wait_stb(1, 0, 'h011, 40, "B_ch0_after_err");

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            WR_VALID = ($urandom_range(0, 2) == 0);
            WR_CH    = 2'($urandom_range(0, 3));
            WR_DATA  = 10'($urandom);
            LDAC     = ($urandom_range(0, 11) == 0);
            PD       = ($urandom_range(0, 149) == 0);
            tick();
        end
        idle();
        PD = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        check("B_err_sticky", 32'(b_err), 32'd1);

        // power-down mid-run keeps shadows, clears active values
        write(2'd2, 10'h1A5, 1'b1);
        wait_stb(0, 2, 'h1A5, 80, "A_ch2_loaded");
        PD = 1'b1;
        tick();
        check("A_data_zero_after_pd", 32'(a_data), 32'd0);
        tick();
        tick();
        PD = 1'b0;
        tick();
        check("A_settle_again", 32'(a_dbg), 32'(SETTLE));
        wait_stb(0, 0, 0, 60, "A_first_stb_after_pd");
        wait_stb(0, 2, 0, 80, "A_ch2_zero_after_pd");
        LDAC = 1'b1; tick(); idle();
        wait_stb(0, 2, 'h1A5, 80, "A_ch2_shadow_kept");

        // asynchronous reset mid-cycle
        @(negedge CLK);
        #2;
        RST = 1'b1;
        model_reset();
        #1;
        compare_dut(0);
        compare_dut(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
